// File: rtl/mult_shift_add_datapath.sv
// Register datapath of the shift-add multiplier: accumulator A, shifted
// multiplicand B, multiplier Q and iteration counter N, each steered by a 2-bit select.
module mult_shift_add_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [1:0]         B_sel,
    input  logic [1:0]         Q_sel,
    input  logic [1:0]         A_sel,
    input  logic [1:0]         N_sel,
    output logic [WIDTH-1:0]   Qsub0,
    output logic [WIDTH-1:0]   N,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam logic [1:0] SEL_LOAD  = 2'b00;
    localparam logic [1:0] SEL_OP    = 2'b01;
    localparam logic [1:0] SEL_HOLD  = 2'b10;
    localparam logic [1:0] SEL_CLEAR = 2'b11;

    localparam logic [WIDTH-1:0] N_LOAD = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] N_ONE  = WIDTH'(1);

    logic [2*WIDTH-1:0] a_q, a_d;
    logic [2*WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   n_q, n_d;
    logic               done_q, done_d;

    // Every next-state value is built only from pre-edge register contents,
    // so any mix of selects in one cycle is well defined.
    always_comb begin
        a_d = a_q;
        unique case (A_sel)
            SEL_LOAD:  a_d = '0;
            SEL_OP:    a_d = a_q + b_q;
            SEL_HOLD:  a_d = a_q;
            SEL_CLEAR: a_d = '0;
            default:   a_d = a_q;
        endcase
    end

    always_comb begin
        b_d = b_q;
        unique case (B_sel)
            SEL_LOAD:  b_d = {{WIDTH{1'b0}}, multiplicand};
            SEL_OP:    b_d = {b_q[2*WIDTH-2:0], 1'b0};
            SEL_HOLD:  b_d = b_q;
            SEL_CLEAR: b_d = '0;
            default:   b_d = b_q;
        endcase
    end

    always_comb begin
        q_d = q_q;
        unique case (Q_sel)
            SEL_LOAD:  q_d = multiplier;
            SEL_OP:    q_d = {1'b0, q_q[WIDTH-1:1]};
            SEL_HOLD:  q_d = q_q;
            SEL_CLEAR: q_d = '0;
            default:   q_d = q_q;
        endcase
    end

    // Decrement saturates at zero so a stray extra decrement cannot restart a count.
    always_comb begin
        n_d = n_q;
        unique case (N_sel)
            SEL_LOAD:  n_d = N_LOAD;
            SEL_OP:    n_d = (n_q == '0) ? '0 : n_q - N_ONE;
            SEL_HOLD:  n_d = n_q;
            SEL_CLEAR: n_d = '0;
            default:   n_d = n_q;
        endcase
    end

    always_comb begin
        done_d = done_q;
        unique case (N_sel)
            SEL_LOAD:  done_d = 1'b0;
            SEL_OP:    done_d = (n_q == N_ONE) ? 1'b1 : done_q;
            SEL_HOLD:  done_d = done_q;
            SEL_CLEAR: done_d = 1'b0;
            default:   done_d = done_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            q_q    <= '0;
            n_q    <= '0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            q_q    <= q_d;
            n_q    <= n_d;
            done_q <= done_d;
        end
    end

    assign Qsub0   = q_q;
    assign N       = n_q;
    assign product = a_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mult_shift_add_datapath.sv
// Self-checking bench for mult_shift_add_datapath: per-cycle register expectations
// go through a scoreboard queue, and full multiplications are checked against a*b.
module tb_mult_shift_add_datapath;

    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [W-1:0]     multiplicand, multiplier;
    logic [1:0]       B_sel, Q_sel, A_sel, N_sel;
    logic [W-1:0]     Qsub0, N;
    logic [2*W-1:0]   product;
    logic             done;

    typedef struct {
        logic [2*W-1:0] a;
        logic [W-1:0]   q;
        logic [W-1:0]   n;
        logic           done;
        string          tag;
    } exp_t;

    exp_t exp_q[$];

    // Reference state kept by the bench; B is internal to the DUT and only
    // observed indirectly through A.
    logic [2*W-1:0] m_a, m_b;
    logic [W-1:0]   m_q, m_n;
    logic           m_done;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    mult_shift_add_datapath #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .B_sel        (B_sel),
        .Q_sel        (Q_sel),
        .A_sel        (A_sel),
        .N_sel        (N_sel),
        .Qsub0        (Qsub0),
        .N            (N),
        .product      (product),
        .done         (done)
    );

    task automatic check_eq(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_step(input logic rst, input logic [1:0] as, input logic [1:0] bs,
                              input logic [1:0] qs, input logic [1:0] ns,
                              input logic [W-1:0] mc, input logic [W-1:0] ml);
        logic [2*W-1:0] na, nb;
        logic [W-1:0]   nq, nn;
        logic           nd;
        if (rst) begin
            m_a = '0; m_b = '0; m_q = '0; m_n = '0; m_done = 1'b0;
            return;
        end
        na = (as == 2'b01) ? m_a + m_b : (as == 2'b10) ? m_a : '0;
        case (bs)
            2'b00:   nb = {{W{1'b0}}, mc};
            2'b01:   nb = m_b << 1;
            2'b10:   nb = m_b;
            default: nb = '0;
        endcase
        case (qs)
            2'b00:   nq = ml;
            2'b01:   nq = m_q >> 1;
            2'b10:   nq = m_q;
            default: nq = '0;
        endcase
        nd = m_done;
        case (ns)
            2'b00:   begin nn = 32; nd = 1'b0; end
            2'b01:   begin
                         nn = (m_n == 0) ? '0 : m_n - 1;
                         if (m_n == 1) nd = 1'b1;
                     end
            2'b10:   nn = m_n;
            default: begin nn = '0; nd = 1'b0; end
        endcase
        m_a = na; m_b = nb; m_q = nq; m_n = nn; m_done = nd;
    endtask

    // One clock: drive on the falling edge, queue the expectation, compare after the rising edge.
    task automatic cycle(input string tag, input logic rst, input logic [1:0] as, input logic [1:0] bs,
                         input logic [1:0] qs, input logic [1:0] ns,
                         input logic [W-1:0] mc, input logic [W-1:0] ml);
        exp_t e;
        @(negedge clk);
        reset = rst; A_sel = as; B_sel = bs; Q_sel = qs; N_sel = ns;
        multiplicand = mc; multiplier = ml;
        model_step(rst, as, bs, qs, ns, mc, ml);
        e.a = m_a; e.q = m_q; e.n = m_n; e.done = m_done; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq({e.tag, ".product"}, product, e.a);
        check_eq({e.tag, ".Q"}, {{W{1'b0}}, Qsub0}, {{W{1'b0}}, e.q});
        check_eq({e.tag, ".N"}, {{W{1'b0}}, N}, {{W{1'b0}}, e.n});
        check_eq({e.tag, ".done"}, {{(2*W-1){1'b0}}, done}, {{(2*W-1){1'b0}}, e.done});
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        cycle("load", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, a, b);
    endtask

    task automatic iterate(input int count);
        for (int i = 0; i < count; i++)
            cycle("iter", 1'b0, Qsub0[0] ? 2'b01 : 2'b10, 2'b01, 2'b01, 2'b01, '0, '0);
    endtask

    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] want;
        want = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        load(a, b);
        iterate(W);
        $display("mult 0x%0h x 0x%0h -> product 0x%0h done %0b", a, b, product, done);
        check_eq("mult.product", product, want);
        check_eq("mult.done", {{(2*W-1){1'b0}}, done}, 64'd1);
    endtask

    initial begin
        reset = 1'b0; multiplicand = '0; multiplier = '0;
        A_sel = 2'b10; B_sel = 2'b10; Q_sel = 2'b10; N_sel = 2'b10;
        m_a = '0; m_b = '0; m_q = '0; m_n = '0; m_done = 1'b0;

        cycle("reset0", 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 32'hDEAD, 32'hBEEF);
        cycle("reset1", 1'b1, 2'b11, 2'b01, 2'b01, 2'b01, 32'h1, 32'h2);
        $display("reset -> product 0x%0h Q 0x%0h N %0d done %0b", product, Qsub0, N, done);

        load(32'd5, 32'd3);
        check_eq("load5x3.N", {{W{1'b0}}, N}, 64'd32);
        cycle("allop", 1'b0, 2'b01, 2'b01, 2'b01, 2'b01, '0, '0);
        check_eq("allop.A", product, 64'd5);
        check_eq("allop.Q", {{W{1'b0}}, Qsub0}, 64'd1);
        check_eq("allop.N", {{W{1'b0}}, N}, 64'd31);
        // B=10 is observable by adding it into A=5
        cycle("addB", 1'b0, 2'b01, 2'b10, 2'b10, 2'b10, '0, '0);
        check_eq("addB.A", product, 64'd15);
        $display("single-step checks done, product %0d", product);

        run_mult(32'hFFFFFFFF, 32'hFFFFFFFF);
        check_eq("maxmax.literal", product, 64'hFFFFFFFE00000001);
        run_mult(32'h0, 32'h12345678);
        run_mult(32'h12345678, 32'h9ABCDEF0);
        for (int k = 0; k < 3; k++) run_mult($urandom, $urandom);

        // Saturation boundary: walk N down to 1 holding the other registers.
        load(32'd1, 32'd1);
        for (int i = 0; i < W - 1; i++)
            cycle("walk", 1'b0, 2'b10, 2'b10, 2'b10, 2'b01, '0, '0);
        check_eq("walk.N", {{W{1'b0}}, N}, 64'd1);
        check_eq("walk.done", {{(2*W-1){1'b0}}, done}, 64'd0);
        cycle("dec1", 1'b0, 2'b10, 2'b10, 2'b10, 2'b01, '0, '0);
        check_eq("dec1.done", {{(2*W-1){1'b0}}, done}, 64'd1);
        cycle("sat", 1'b0, 2'b10, 2'b10, 2'b10, 2'b01, '0, '0);
        check_eq("sat.N", {{W{1'b0}}, N}, 64'd0);
        check_eq("sat.done", {{(2*W-1){1'b0}}, done}, 64'd1);
        cycle("reload", 1'b0, 2'b10, 2'b10, 2'b10, 2'b00, '0, '0);
        check_eq("reload.N", {{W{1'b0}}, N}, 64'd32);
        check_eq("reload.done", {{(2*W-1){1'b0}}, done}, 64'd0);
        $display("saturation sequence done, N %0d done %0b", N, done);

        // Clear select drops done.
        cycle("walk2", 1'b0, 2'b10, 2'b10, 2'b10, 2'b11, '0, '0);
        check_eq("clearN.done", {{(2*W-1){1'b0}}, done}, 64'd0);

        // Reset in the middle of a multiplication.
        load(32'hABCD, 32'h1234);
        iterate(15);
        check_eq("mid.N", {{W{1'b0}}, N}, 64'd17);
        cycle("midreset", 1'b1, 2'b01, 2'b01, 2'b01, 2'b01, '0, '0);
        check_eq("midreset.product", product, 64'd0);
        check_eq("midreset.N", {{W{1'b0}}, N}, 64'd0);
        run_mult(32'd7, 32'd9);
        check_eq("7x9.literal", product, 64'd63);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
